// File: rtl/monkey_game_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// monkey_game_pkg : shared game phase encoding and screen/frame constants
// Revision 1.0
// ---------------------------------------------------------------------------
package monkey_game_pkg;

    localparam int FRAME_RATE = 30;
    localparam int SCREEN_H   = 480;

    typedef enum logic [2:0] {
        PH_IDLE      = 3'd0,
        PH_SPAWN     = 3'd1,
        PH_PLAY      = 3'd2,
        PH_DYING     = 3'd3,
        PH_WIN       = 3'd4,
        PH_GAME_OVER = 3'd5
    } game_phase_t;

    function automatic logic [2:0] lives_dec(input logic [2:0] lives);
        return (lives != 3'd0) ? lives - 3'd1 : 3'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/monkey_life_ctrl_frame_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// frame_timer : loadable 8-bit frame down-counter with zero/last-tick flags
// Revision 1.0
// ---------------------------------------------------------------------------
module frame_timer (
    input  logic       clk,
    input  logic       resetN,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       tick,
    output logic       done,
    output logic       expire
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (tick && (count_q != 8'd0)) begin
            count_d = count_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // expire marks the tick that brings the count to zero
    assign done   = (count_q == 8'd0);
    assign expire = tick && (count_q == 8'd1);

endmodule
`default_nettype wire

// File: rtl/monkey_life_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// monkey_life_ctrl : monkey game-phase controller (spawn, play, death, win)
// Revision 1.0
// ---------------------------------------------------------------------------
module monkey_life_ctrl
    import monkey_game_pkg::*;
#(
    parameter int INIT_LIVES    = 3,
    parameter int SPAWN_FRAMES  = FRAME_RATE / 2,
    parameter int DEATH_FRAMES  = (FRAME_RATE * 3) / 2,
    parameter int INVULN_FRAMES = FRAME_RATE * 3,
    parameter int BLINK_SHIFT   = 2,
    parameter int FLOOR_Y       = SCREEN_H - 20
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        startGame,
    input  logic        enemyHit,
    input  logic        goalHit,
    input  logic [10:0] topLeftY,
    output logic        moveEnable,
    output logic        respawnN,
    output logic [2:0]  livesLeft,
    output logic        invulnerable,
    output logic        monkeyVisible,
    output logic        gameOver,
    output logic        levelWin,
    output logic [2:0]  phase
);

    localparam logic signed [10:0] FLOOR_Y_S    = 11'(FLOOR_Y);
    localparam logic [2:0]         INIT_LIVES_L = 3'(INIT_LIVES);

    game_phase_t state_q, state_d;
    logic [2:0]  lives_q, lives_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        respawn_n_q, respawn_n_d;
    logic        move_enable_q, move_enable_d;
    logic        invulnerable_q, invulnerable_d;
    logic        visible_q, visible_d;
    logic        game_over_q, game_over_d;
    logic        level_win_q, level_win_d;

    logic        ph_load;
    logic [7:0]  ph_load_val;
    logic        ph_done;
    logic        ph_expire;
    logic        inv_done;
    logic        inv_expire;
    logic        phase_end;
    logic        fell;

    frame_timer u_phase_timer (
        .clk      (clk),
        .resetN   (resetN),
        .load     (ph_load),
        .load_val (ph_load_val),
        .tick     (startOfFrame),
        .done     (ph_done),
        .expire   (ph_expire)
    );

    // Held at full value outside PLAY so the window starts on PLAY entry
    frame_timer u_invuln_timer (
        .clk      (clk),
        .resetN   (resetN),
        .load     (state_q != PH_PLAY),
        .load_val (8'(INVULN_FRAMES)),
        .tick     (startOfFrame),
        .done     (inv_done),
        .expire   (inv_expire)
    );

    assign phase_end   = ph_expire || (startOfFrame && ph_done);
    assign fell        = $signed(topLeftY) > FLOOR_Y_S;
    assign ph_load     = (state_d != state_q) &&
                         ((state_d == PH_SPAWN) || (state_d == PH_DYING));
    assign ph_load_val = (state_d == PH_SPAWN) ? 8'(SPAWN_FRAMES) : 8'(DEATH_FRAMES);

    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        frame_cnt_d = frame_cnt_q;
        respawn_n_d = 1'b1;
        case (state_q)
            PH_IDLE, PH_WIN, PH_GAME_OVER: begin
                if (startGame) begin
                    state_d     = PH_SPAWN;
                    lives_d     = INIT_LIVES_L;
                    frame_cnt_d = 8'd0;
                    respawn_n_d = 1'b0;
                end
            end
            PH_SPAWN: begin
                if (startOfFrame) begin
                    if (phase_end) begin
                        state_d     = PH_PLAY;
                        frame_cnt_d = 8'd0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
            end
            PH_PLAY: begin
                if (startOfFrame) begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end
                if (goalHit) begin
                    state_d = PH_WIN;
                end else if (fell || (enemyHit && inv_done)) begin
                    state_d     = PH_DYING;
                    lives_d     = lives_dec(lives_q);
                    frame_cnt_d = 8'd0;
                end
            end
            PH_DYING: begin
                if (startOfFrame) begin
                    if (phase_end) begin
                        frame_cnt_d = 8'd0;
                        if (lives_q == 3'd0) begin
                            state_d = PH_GAME_OVER;
                        end else begin
                            state_d     = PH_SPAWN;
                            respawn_n_d = 1'b0;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = PH_IDLE;
            end
        endcase
    end

    // Outputs are decoded from next-state values so they line up with phase
    always_comb begin
        move_enable_d  = (state_d == PH_PLAY);
        invulnerable_d = (state_d == PH_PLAY) && !(inv_done || inv_expire);
        game_over_d    = (state_d == PH_GAME_OVER);
        level_win_d    = (state_d == PH_WIN);
        case (state_d)
            PH_IDLE, PH_GAME_OVER: visible_d = 1'b0;
            PH_PLAY:               visible_d = invulnerable_d ? frame_cnt_d[BLINK_SHIFT] : 1'b1;
            default:               visible_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q        <= PH_IDLE;
            lives_q        <= 3'd0;
            frame_cnt_q    <= 8'd0;
            respawn_n_q    <= 1'b1;
            move_enable_q  <= 1'b0;
            invulnerable_q <= 1'b0;
            visible_q      <= 1'b0;
            game_over_q    <= 1'b0;
            level_win_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            lives_q        <= lives_d;
            frame_cnt_q    <= frame_cnt_d;
            respawn_n_q    <= respawn_n_d;
            move_enable_q  <= move_enable_d;
            invulnerable_q <= invulnerable_d;
            visible_q      <= visible_d;
            game_over_q    <= game_over_d;
            level_win_q    <= level_win_d;
        end
    end

    assign moveEnable    = move_enable_q;
    assign respawnN      = respawn_n_q;
    assign livesLeft     = lives_q;
    assign invulnerable  = invulnerable_q;
    assign monkeyVisible = visible_q;
    assign gameOver      = game_over_q;
    assign levelWin      = level_win_q;
    assign phase         = state_q;

endmodule
`default_nettype wire

// File: tb/tb_monkey_life_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_monkey_life_ctrl : scoreboard bench, one expected entry per output change
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_monkey_life_ctrl;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic        startGame = 1'b0;
    logic        enemyHit = 1'b0;
    logic        goalHit = 1'b0;
    logic [10:0] topLeftY = 11'd100;

    logic        moveEnable;
    logic        respawnN;
    logic [2:0]  livesLeft;
    logic        invulnerable;
    logic        monkeyVisible;
    logic        gameOver;
    logic        levelWin;
    logic [2:0]  phase;

    always #5 clk = ~clk;

    monkey_life_ctrl dut (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (startOfFrame),
        .startGame     (startGame),
        .enemyHit      (enemyHit),
        .goalHit       (goalHit),
        .topLeftY      (topLeftY),
        .moveEnable    (moveEnable),
        .respawnN      (respawnN),
        .livesLeft     (livesLeft),
        .invulnerable  (invulnerable),
        .monkeyVisible (monkeyVisible),
        .gameOver      (gameOver),
        .levelWin      (levelWin),
        .phase         (phase)
    );

    localparam logic [11:0] M_ALL   = 12'hFFF;
    localparam logic [11:0] M_NOVIS = 12'hFF7;

    logic [11:0] exp_q[$];
    logic [11:0] mask_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;

    logic [11:0] obs;
    logic [11:0] prev_obs;
    logic [11:0] e_val;
    logic [11:0] e_mask;
    string       e_name;

    assign obs = {phase, livesLeft, moveEnable, invulnerable, monkeyVisible,
                  gameOver, levelWin, respawnN};

    function automatic logic [11:0] mk(input logic [2:0] ph, input logic [2:0] lv,
                                       input logic me, input logic inv, input logic vis,
                                       input logic go, input logic win, input logic rn);
        return {ph, lv, me, inv, vis, go, win, rn};
    endfunction

    task automatic expect_out(input string nm, input logic [11:0] v, input logic [11:0] m);
        name_q.push_back(nm);
        exp_q.push_back(v);
        mask_q.push_back(m);
    endtask

    // Monitor: every change of the observed output vector consumes one entry
    initial begin
        prev_obs = 12'h000;
        forever begin
            @(negedge clk);
            if (obs !== prev_obs) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: got %h want no change from %h", obs, prev_obs);
                end else begin
                    e_name = name_q.pop_front();
                    e_val  = exp_q.pop_front();
                    e_mask = mask_q.pop_front();
                    if ((obs & e_mask) !== (e_val & e_mask)) begin
                        errors++;
                        $display("FAIL %s: got %h want %h", e_name, obs & e_mask, e_val & e_mask);
                    end
                end
                prev_obs = obs;
            end
        end
    end

    initial begin
        #400000;
        errors++;
        checks++;
        $display("FAIL watchdog: got timeout want finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1;
            step();
            startOfFrame = 1'b0;
            repeat (3) step();
        end
    endtask

    task automatic restart();
        expect_out("start_spawn", mk(3'd1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), M_ALL);
        expect_out("start_pulse_end", mk(3'd1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1), M_ALL);
        startGame = 1'b1;
        step();
        startGame = 1'b0;
        step();
    endtask

    task automatic spawn_to_play(input logic [2:0] lv);
        expect_out("enter_play", mk(3'd2, lv, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), M_ALL);
        frames(15);
    endtask

    task automatic play_invuln(input logic [2:0] lv, input logic hold_enemy);
        for (int k = 1; k <= 90; k++) begin
            if (k == 90)
                expect_out("invuln_end", mk(3'd2, lv, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1), M_ALL);
            else if ((k % 4) == 0)
                expect_out("blink", mk(3'd2, lv, 1'b1, 1'b1, k[2], 1'b0, 1'b0, 1'b1), M_ALL);
            enemyHit = hold_enemy && (k < 90);
            frames(1);
        end
        enemyHit = 1'b0;
    endtask

    task automatic fall(input logic [2:0] lv_after);
        expect_out("fall_die", mk(3'd3, lv_after, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1), M_ALL);
        topLeftY = 11'd461;
        step();
        topLeftY = 11'd100;
        step();
    endtask

    task automatic expect_respawn(input logic [2:0] lv);
        expect_out("respawn", mk(3'd1, lv, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), M_ALL);
        expect_out("respawn_pulse_end", mk(3'd1, lv, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1), M_ALL);
    endtask

    initial begin
        expect_out("reset", mk(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), M_ALL);
        repeat (3) step();
        resetN = 1'b1;
        step();

        // First life: enemy contact ignored throughout the immunity window
        restart();
        spawn_to_play(3'd3);
        play_invuln(3'd3, 1'b1);
        expect_out("enemy_die", mk(3'd3, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1), M_ALL);
        enemyHit = 1'b1;
        step();
        enemyHit = 1'b0;
        step();

        // Hits and restart requests are ignored while dying and spawning
        expect_respawn(3'd2);
        goalHit = 1'b1;
        enemyHit = 1'b1;
        startGame = 1'b1;
        frames(5);
        goalHit = 1'b0;
        enemyHit = 1'b0;
        startGame = 1'b0;
        frames(40);
        expect_out("enter_play", mk(3'd2, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), M_ALL);
        startGame = 1'b1;
        frames(3);
        startGame = 1'b0;
        frames(12);

        // Floor boundary: 460 and negative Y stay in play, 461 kills
        topLeftY = 11'd460;
        repeat (3) step();
        topLeftY = 11'h7FB;
        repeat (3) step();
        fall(3'd1);
        expect_respawn(3'd1);
        frames(45);
        spawn_to_play(3'd1);
        play_invuln(3'd1, 1'b0);

        // Goal beats enemy in the same clk
        expect_out("win", mk(3'd4, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), M_NOVIS);
        goalHit = 1'b1;
        enemyHit = 1'b1;
        step();
        goalHit = 1'b0;
        enemyHit = 1'b0;
        frames(3);

        // Three deaths to game over, then restart
        restart();
        spawn_to_play(3'd3);
        fall(3'd2);
        expect_respawn(3'd2);
        frames(45);
        spawn_to_play(3'd2);
        fall(3'd1);
        expect_respawn(3'd1);
        frames(45);
        spawn_to_play(3'd1);
        fall(3'd0);
        expect_out("game_over", mk(3'd5, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1), M_NOVIS);
        frames(45);
        frames(2);
        restart();
        spawn_to_play(3'd3);
        fall(3'd2);

        // Reset in the middle of the death animation
        frames(20);
        expect_out("mid_reset", mk(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), M_ALL);
        #2;
        resetN = 1'b0;
        repeat (3) step();
        resetN = 1'b1;
        frames(50);

        repeat (5) step();
        while (exp_q.size() != 0) begin
            checks++;
            errors++;
            e_name = name_q.pop_front();
            e_val  = exp_q.pop_front();
            void'(mask_q.pop_front());
            $display("FAIL %s: got no output change want %h", e_name, e_val);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/monkey_life_ctrl.md
Name: monkey_life_ctrl

Overview:
- Game-phase controller for the player monkey.
- Gates the monkey move/collision datapath (move enable, respawn reset pulse) and decides death, respawn, invulnerability, win and game over.
- Sits between the collision/hit detectors and the monkey move block; its outputs also feed the score/lives display and the monkey bitmap (visibility blink).
- All timing is counted in frames using startOfFrame (30 Hz).

Parameters:
- INIT_LIVES, 3, lives loaded at game start (1..7).
- SPAWN_FRAMES, 15, frames the monkey is frozen after a respawn before control is enabled.
- DEATH_FRAMES, 45, frames the death animation runs (monkey frozen, visible).
- INVULN_FRAMES, 90, frames of enemy-hit immunity after control is enabled.
- BLINK_SHIFT, 2, visibility toggles every 2^BLINK_SHIFT frames while invulnerable.
- FLOOR_Y, 460, topLeftY strictly greater than this means the monkey fell off screen (death).

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous, active-low reset.
- startOfFrame  in  1  one-clk pulse per frame.
- startGame  in  1  one-clk pulse from the keyboard/menu to start or restart.
- enemyHit  in  1  level: monkey overlaps an enemy this clk.
- goalHit  in  1  level: monkey overlaps the goal (key) object.
- topLeftY  in  11 signed  monkey Y position from the move block.
- moveEnable  out  1  high only in PLAY; top level forces the move block's key inputs to 0 when low.
- respawnN  out  1  active-low one-clk pulse; top level ANDs it into the move block's resetN.
- livesLeft  out  3  remaining lives.
- invulnerable  out  1  immunity window active.
- monkeyVisible  out  1  bitmap draw enable.
- gameOver  out  1  high in GAME_OVER.
- levelWin  out  1  high in WIN.
- phase  out  3  current state encoding, for debug/display.

Behaviour:
- States and encoding: IDLE=0, SPAWN=1, PLAY=2, DYING=3, WIN=4, GAME_OVER=5.
- Registers: 8-bit frameCnt, 8-bit invulnCnt.
- Reset values: state=IDLE, livesLeft=0, frameCnt=0, invulnCnt=0, moveEnable=0, respawnN=1, invulnerable=0, monkeyVisible=0, gameOver=0, levelWin=0, phase=0.
- Outputs are registered: one clk latency from the state change.
- IDLE:
  - startGame -> SPAWN; livesLeft<=INIT_LIVES, frameCnt<=0, respawnN pulses low for exactly one clk.
  - monkeyVisible=0.
- SPAWN:
  - monkeyVisible=1, moveEnable=0.
  - frameCnt increments on startOfFrame.
  - When frameCnt reaches SPAWN_FRAMES-1 on a startOfFrame -> PLAY; invulnCnt<=INVULN_FRAMES, frameCnt<=0.
- PLAY:
  - moveEnable=1.
  - invulnerable = (invulnCnt != 0); invulnCnt decrements on startOfFrame and saturates at 0.
  - While invulnerable: monkeyVisible = frameCnt[BLINK_SHIFT]; otherwise monkeyVisible=1. frameCnt free-runs (wraps at 255) in PLAY.
  - Priority within one clk: goalHit > fall > enemyHit.
    - goalHit -> WIN.
    - fall (topLeftY > FLOOR_Y, signed compare) -> DYING regardless of invulnerability.
    - enemyHit && !invulnerable -> DYING.
  - Entering DYING: livesLeft decrements (never below 0), frameCnt<=0.
- DYING:
  - moveEnable=0, monkeyVisible=1, invulnerable=0.
  - After DEATH_FRAMES startOfFrame pulses:
    - livesLeft==0 -> GAME_OVER.
    - else -> SPAWN with a respawnN pulse.
  - enemyHit and goalHit are ignored.
- WIN and GAME_OVER:
  - Outputs levelWin or gameOver =1, moveEnable=0.
  - startGame -> IDLE behaviour in the same clk: go to SPAWN with a full life reload and a respawnN pulse.
- startGame in SPAWN/PLAY/DYING: ignored.
- Counter events happen only on the clk where startOfFrame=1. Hit inputs are sampled every clk.
- resetN asserted mid-operation: immediate return to reset values. No pending respawn pulse is emitted.

Decomposition:
- Package monkey_game_pkg holds:
  - typedef enum logic[2:0] game_phase_t with the six states above;
  - constants FRAME_RATE=30 and SCREEN_H=480, shared with the move block and display.
- One sub-module, frame_timer: loadable 8-bit down-counter clocked by startOfFrame with a done flag. Instantiated twice, for the phase timer and the invulnerability timer.

Test Plan:
- Reset, then startGame pulse -> respawnN low for exactly 1 clk, livesLeft=3, phase=1; after 15 frames phase=2, moveEnable=1, invulnerable=1.
- enemyHit during the first 90 frames of PLAY -> no state change; at frame 91, enemyHit -> phase=3, livesLeft=2, moveEnable=0 next clk.
- In PLAY drive topLeftY=461 while invulnerable -> DYING. topLeftY=460 -> stays in PLAY. topLeftY=-5 -> stays in PLAY.
- goalHit and enemyHit in the same clk with invulnerable=0 -> phase=4, levelWin=1, livesLeft unchanged.
- Three deaths -> after the third DYING's 45 frames, phase=5, gameOver=1, livesLeft=0; a startGame pulse -> livesLeft=3, phase=1, one respawnN pulse.
- Assert resetN during DYING at frame 20 -> all outputs at reset values the same clk; respawnN stays 1.
